// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter: FSM state encodings and grant indices.
package mem_arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes to the
// port that was not granted last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic pick
);

    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else if (req1) begin
            pick = PORT_LDR;
        end else begin
            pick = PORT_CPU;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between the CPU (port 0) and a loader (port 1),
// one transaction at a time, with a ready handshake and an access timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          cpu_stall,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          grant_q, grant_d;
    logic          we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          pick_valid;
    logic          pick;

    rr_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .pick       (pick)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    addr_d       = (pick == PORT_LDR) ? addr1 : addr0;
                    wdata_d      = (pick == PORT_LDR) ? wdata1 : wdata0;
                    we_d         = (pick == PORT_LDR) ? we1 : we0;
                    rd_d         = ~we_d;
                    wr_d         = we_d;
                    cnt_d        = '0;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready || cnt_q == CNT_MAX) begin
                    // Timeout still completes the transaction so the requester never hangs.
                    if (!mem_ready) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ack0_d  = (grant_q == PORT_CPU);
                    ack1_d  = (grant_q == PORT_LDR);
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_LDR;
            grant_q      <= PORT_CPU;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rd    = rd_q;
    assign mem_wr    = wr_q;
    assign cpu_stall = req0 & ~ack0_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter and a small memory array.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, cpu_stall, err, mem_rd, mem_wr, mem_ready;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_port_arbiter #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .cpu_stall (cpu_stall),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h10; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (2) tick();
        tests_run++; if ({mem_rd, mem_wr, ack0, ack1, err} !== 5'b0) begin tests_failed++;
            $display("FAIL reset_ctrl: got %b want 00000", {mem_rd, mem_wr, ack0, ack1, err}); end
        tests_run++; if (rdata !== 32'h0 || mem_addr !== 32'h0) begin tests_failed++;
            $display("FAIL reset_data: rdata=%h addr=%h want 0", rdata, mem_addr); end
        tests_run++; if (cpu_stall !== 1'b1) begin tests_failed++;
            $display("FAIL reset_stall: got %b want 1", cpu_stall); end
    endtask

    task automatic test_first_read();
        rst = 1'b1;
        tick();
        tests_run++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h10) begin
            tests_failed++;
            $display("FAIL t1_strobe: rd=%b wr=%b addr=%h want 1 0 10", mem_rd, mem_wr, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        tests_run++; if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL t1_ack: ack0=%b ack1=%b rdata=%h want 1 0 deadbeef", ack0, ack1, rdata);
        end
        tests_run++; if (cpu_stall !== 1'b0 || mem_rd !== 1'b0) begin tests_failed++;
            $display("FAIL t1_stall: stall=%b rd=%b want 0 0", cpu_stall, mem_rd); end
        req0 = 1'b0; mem_ready = 1'b0;
        tick();
        tests_run++; if (ack0 !== 1'b0) begin tests_failed++;
            $display("FAIL t1_ack_pulse: got %b want 0", ack0); end
    endtask

    task automatic test_write_wait();
        int wr_cycles = 0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h12345678;
        mem_rdata = 32'h0BAD0BAD;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (mem_wr === 1'b1) wr_cycles++;
            tests_run++;
            if (mem_rd !== 1'b0 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678) begin
                tests_failed++;
                $display("FAIL t3_stable c%0d: rd=%b addr=%h data=%h", c, mem_rd, mem_addr,
                         mem_wdata);
            end
        end
        mem_ready = 1'b1;
        tick();
        tests_run++; if (wr_cycles != 4 || mem_wr !== 1'b0) begin tests_failed++;
            $display("FAIL t3_wr_len: got %0d cycles wr=%b want 4 0", wr_cycles, mem_wr); end
        tests_run++; if (ack1 !== 1'b1 || ack0 !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL t3_ack: ack1=%b ack0=%b rdata=%h want 1 0 deadbeef", ack1, ack0, rdata);
        end
        req1 = 1'b0; we1 = 1'b0; mem_ready = 1'b0;
        tick();
        tests_run++; if (ack1 !== 1'b0) begin tests_failed++;
            $display("FAIL t3_ack_once: got %b want 0", ack1); end
    endtask

    task automatic test_fairness();
        int   order[$];
        logic last = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h4; addr1 = 32'h8; mem_ready = 1'b1; mem_rdata = 32'h55AA55AA;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (ack1 === 1'b1) order.push_back(1);
            if (ack0 === 1'b1) order.push_back(0);
            tests_run++; if (cpu_stall !== ~ack0) begin tests_failed++;
                $display("FAIL t2_stall c%0d: got %b ack0=%b", c, cpu_stall, ack0); end
        end
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
        tests_run++; if (order.size() != 4) begin tests_failed++;
            $display("FAIL t2_count: got %0d acks want 4", order.size()); end
        for (int i = 0; i < order.size() && i < 4; i++) begin
            last = ~last;
            tests_run++; if (order[i] != int'(last)) begin tests_failed++;
                $display("FAIL t2_order[%0d]: got %0d want %0d", i, order[i], last); end
        end
        tick();
    endtask

    task automatic test_timeout();
        int rd_cycles = 0;
        bit seen = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h80; mem_ready = 1'b0;
        tick();
        for (int c = 0; c < 40 && !seen; c++) begin
            if (mem_rd === 1'b1) rd_cycles++;
            if (err !== 1'b0 && !seen) begin
                tests_run++; tests_failed++;
                $display("FAIL t4_err_early: got %b want 0 at c%0d", err, c);
            end
            tick();
            if (ack0 === 1'b1) seen = 1'b1;
        end
        tests_run++; if (!seen || rd_cycles != 16) begin tests_failed++;
            $display("FAIL t4_len: ack_seen=%b rd_cycles=%0d want 1 16", seen, rd_cycles); end
        tests_run++; if (err !== 1'b1 || rdata !== 32'h0) begin tests_failed++;
            $display("FAIL t4_abort: err=%b rdata=%h want 1 0", err, rdata); end
        req0 = 1'b0;
        tick();
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'hC0;
        tick();
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        tests_run++; if (ack1 !== 1'b1 || rdata !== 32'hCAFEF00D || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL t4_sticky: ack1=%b rdata=%h err=%b want 1 cafef00d 1", ack1, rdata, err);
        end
        req1 = 1'b0; mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_late_req();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        tick();
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h100;
        tick();
        tests_run++; if (mem_addr !== 32'h20 || ack1 !== 1'b0 || mem_rd !== 1'b1) begin
            tests_failed++;
            $display("FAIL t5_hold: addr=%h ack1=%b rd=%b want 20 0 1", mem_addr, ack1, mem_rd);
        end
        mem_ready = 1'b1; mem_rdata = 32'h11112222;
        tick();
        tests_run++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin tests_failed++;
            $display("FAIL t5_ack0: ack0=%b ack1=%b want 1 0", ack0, ack1); end
        req0 = 1'b0; mem_ready = 1'b0;
        tick();
        req0 = 1'b1;
        tick();
        tests_run++; if (mem_addr !== 32'h100 || mem_rd !== 1'b1) begin tests_failed++;
            $display("FAIL t5_grant1: addr=%h rd=%b want 100 1", mem_addr, mem_rd); end
        mem_ready = 1'b1; mem_rdata = 32'h33334444;
        tick();
        tests_run++; if (ack1 !== 1'b1 || ack0 !== 1'b0 || rdata !== 32'h33334444) begin
            tests_failed++;
            $display("FAIL t5_ack1: ack1=%b ack0=%b rdata=%h want 1 0 33334444", ack1, ack0, rdata);
        end
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
        tick();
    endtask

    // Random transactions against a transaction-level model: round-robin choice from the
    // request pattern and a 16-word memory holding what reads must return.
    task automatic test_random();
        logic [31:0] mem_model [16];
        logic        model_last = 1'b1;  // last grant after test_late_req was port 1
        logic [31:0] exp_rdata = 32'h33334444;
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        for (int n = 0; n < 40; n++) begin
            int unsigned r    = $urandom_range(1, 3);
            int unsigned lat  = $urandom_range(0, 3);
            int unsigned idx0 = $urandom_range(0, 15);
            int unsigned idx1 = $urandom_range(0, 15);
            logic        g, wg;
            int unsigned ig;
            logic [31:0] dg;
            req0 = r[0]; req1 = r[1];
            we0 = 1'($urandom); we1 = 1'($urandom);
            addr0 = idx0 * 4; addr1 = idx1 * 4;
            wdata0 = $urandom; wdata1 = $urandom;
            g  = (req0 && req1) ? ~model_last : req1;
            wg = g ? we1 : we0;
            ig = g ? idx1 : idx0;
            dg = g ? wdata1 : wdata0;
            tick();
            tests_run++;
            if (mem_rd !== ~wg || mem_wr !== wg || mem_addr !== ig * 4 ||
                (wg && mem_wdata !== dg)) begin
                tests_failed++;
                $display("FAIL rnd_strobe n%0d: rd=%b wr=%b addr=%h want wr=%b addr=%h", n,
                         mem_rd, mem_wr, mem_addr, wg, ig * 4);
            end
            for (int w = 0; w < int'(lat); w++) begin
                mem_rdata = $urandom;
                tick();
                tests_run++; if (mem_wr !== wg || ack0 !== 1'b0 || ack1 !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rnd_wait n%0d: wr=%b ack=%b%b want wr=%b", n, mem_wr, ack0,
                             ack1, wg);
                end
            end
            mem_ready = 1'b1;
            mem_rdata = wg ? $urandom : mem_model[ig];
            if (wg) mem_model[ig] = dg;
            else    exp_rdata = mem_model[ig];
            tick();
            tests_run++;
            if (ack0 !== ~g || ack1 !== g || rdata !== exp_rdata || err !== 1'b1 ||
                cpu_stall !== (req0 && g)) begin
                tests_failed++;
                $display("FAIL rnd_ack n%0d: ack=%b%b rdata=%h stall=%b want ack1=%b rdata=%h",
                         n, ack0, ack1, rdata, cpu_stall, g, exp_rdata);
            end
            model_last = g;
            req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h44;
        tick();
        tests_run++; if (mem_rd !== 1'b1) begin tests_failed++;
            $display("FAIL t6_pre: rd=%b want 1", mem_rd); end
        #2 rst = 1'b0;
        #1;
        tests_run++; if ({mem_rd, mem_wr, ack0, ack1, err} !== 5'b0) begin tests_failed++;
            $display("FAIL t6_async: got %b want 00000", {mem_rd, mem_wr, ack0, ack1, err}); end
        req0 = 1'b0; mem_ready = 1'b1;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin tests_failed++;
                $display("FAIL t6_no_ack c%0d: ack=%b%b want 00", c, ack0, ack1); end
        end
        mem_ready = 1'b0;
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h48; addr1 = 32'h4C; we1 = 1'b0;
        tick();
        tests_run++; if (mem_addr !== 32'h48 || mem_rd !== 1'b1) begin tests_failed++;
            $display("FAIL t6_tie: addr=%h rd=%b want 48 1", mem_addr, mem_rd); end
        mem_ready = 1'b1; mem_rdata = 32'h77778888;
        tick();
        tests_run++; if (ack0 !== 1'b1 || rdata !== 32'h77778888) begin tests_failed++;
            $display("FAIL t6_ack0: ack0=%b rdata=%h want 1 77778888", ack0, rdata); end
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_write_wait();
        test_fairness();
        test_timeout();
        test_late_req();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
